// File: rtl/alarm_led_pkg.sv
// Shared constants for the Alarm LED controller: register offsets and reset/limit values.
// The optional PWM dimming feature is selected with ALARM_LED_PWM_EN.
package alarm_led_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE = 3'd3;
    localparam logic [2:0] ADDR_BLINK  = 3'd4;
    localparam logic [2:0] ADDR_PERIOD = 3'd5;
    localparam logic [2:0] ADDR_DUTY   = 3'd6;
    localparam logic [2:0] ADDR_STATUS = 3'd7;

    localparam int unsigned PERIOD_RST = 500;
    localparam logic [7:0]  DUTY_FULL  = 8'd255;
    localparam logic [7:0]  PWM_MAX    = 8'd254;

endpackage

// File: rtl/alarm_led_timebase.sv
// Timebase for the LED controller: tick prescaler, blink half-period counter with phase,
// and (when ALARM_LED_PWM_EN is defined) the free-running PWM counter.
module alarm_led_timebase
    import alarm_led_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic                i_period_wr,
    input  logic [7:0]          i_duty,
    output logic                o_phase,
    output logic                o_pwm_on,
    output logic                o_tick
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]    r_pre;
    logic [PERIOD_W-1:0] r_blink;
    logic                r_phase;
    logic [PERIOD_W-1:0] w_last;
    logic                w_tick;
    logic                w_wrap;

    assign w_tick = (r_pre == PRE_LAST);
    // A zero period behaves like a period of one tick.
    assign w_last = (i_period == '0) ? '0 : (i_period - PERIOD_W'(1));
    assign w_wrap = w_tick && (r_blink == w_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre   <= '0;
            r_blink <= '0;
            r_phase <= 1'b1;
        end else if (i_period_wr) begin
            r_pre   <= '0;
            r_blink <= '0;
            r_phase <= 1'b1;
        end else begin
            r_pre <= w_tick ? '0 : (r_pre + PRE_W'(1));
            if (w_tick) begin
                r_blink <= w_wrap ? '0 : (r_blink + PERIOD_W'(1));
                if (w_wrap) begin
                    r_phase <= ~r_phase;
                end
            end
        end
    end

    assign o_phase = r_phase;
    assign o_tick  = w_tick;

`ifdef ALARM_LED_PWM_EN
    logic [7:0] r_pwm_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == PWM_MAX) ? '0 : (r_pwm_cnt + 8'd1);
        end
    end

    assign o_pwm_on = (r_pwm_cnt < i_duty) || (i_duty == DUTY_FULL);
`else
    logic w_unused_duty;
    assign w_unused_duty = ^i_duty;
    assign o_pwm_on      = 1'b1;
`endif

endmodule

// File: rtl/alarm_led_ctrl.sv
// Avalon-MM LED controller: register file, zero-wait-state read mux and registered LED drive.
// Define ALARM_LED_PWM_EN to include the DUTY register and global PWM dimming.
module alarm_led_ctrl
    import alarm_led_pkg::*;
#(
    parameter int                  NUM_LEDS    = 10,
    parameter int                  PRESCALE    = 50000,
    parameter int                  PERIOD_W    = 16,
    parameter logic [NUM_LEDS-1:0] RESET_VALUE = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [NUM_LEDS-1:0] out_port
);

    logic [NUM_LEDS-1:0] r_data;
    logic [NUM_LEDS-1:0] r_blink;
    logic [PERIOD_W-1:0] r_period;
    logic [NUM_LEDS-1:0] r_out;
    logic [7:0]          w_duty;
    logic                w_wr;
    logic                w_period_wr;
    logic [NUM_LEDS-1:0] w_wd;
    logic                w_phase;
    logic                w_pwm_on;
    logic                w_pwm_status;
    logic                w_tick;
    logic                w_unused;

    assign w_wr        = chipselect && !write_n;
    assign w_period_wr = w_wr && (address == ADDR_PERIOD);
    assign w_wd        = writedata[NUM_LEDS-1:0];
    assign w_unused    = ^{writedata, w_tick};

`ifdef ALARM_LED_PWM_EN
    logic [7:0] r_duty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_duty <= DUTY_FULL;
        end else if (w_wr && (address == ADDR_DUTY)) begin
            r_duty <= writedata[7:0];
        end
    end

    assign w_duty       = r_duty;
    assign w_pwm_status = w_pwm_on;
`else
    assign w_duty       = DUTY_FULL;
    assign w_pwm_status = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= RESET_VALUE;
            r_blink  <= '0;
            r_period <= PERIOD_W'(PERIOD_RST);
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:   r_data   <= w_wd;
                ADDR_SET:    r_data   <= r_data | w_wd;
                ADDR_CLEAR:  r_data   <= r_data & ~w_wd;
                ADDR_TOGGLE: r_data   <= r_data ^ w_wd;
                ADDR_BLINK:  r_blink  <= w_wd;
                ADDR_PERIOD: r_period <= writedata[PERIOD_W-1:0];
                default:     ;
            endcase
        end
    end

    alarm_led_timebase #(
        .PRESCALE (PRESCALE),
        .PERIOD_W (PERIOD_W)
    ) u_timebase (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_period    (r_period),
        .i_period_wr (w_period_wr),
        .i_duty      (w_duty),
        .o_phase     (w_phase),
        .o_pwm_on    (w_pwm_on),
        .o_tick      (w_tick)
    );

    // Blinking channels follow phase, steady channels pass DATA; PWM gates everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
        end else begin
            r_out <= r_data & (~r_blink | {NUM_LEDS{w_phase}}) & {NUM_LEDS{w_pwm_on}};
        end
    end

    assign out_port = r_out;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[NUM_LEDS-1:0] = r_data;
            ADDR_BLINK:  readdata[NUM_LEDS-1:0] = r_blink;
            ADDR_PERIOD: readdata[PERIOD_W-1:0] = r_period;
`ifdef ALARM_LED_PWM_EN
            ADDR_DUTY:   readdata[7:0]          = w_duty;
`endif
            ADDR_STATUS: readdata[1:0]          = {w_pwm_status, w_phase};
            default:     ;
        endcase
    end

endmodule
